// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Shares the single register-file write port between the writeback stage
// (WB, never back-pressured per write) and the multiply/divide unit (MDU,
// valid/ready). One MDU result is buffered and written in the first cycle
// WB leaves the port idle. If WB keeps the port busy for STARVE_MAX cycles
// while a result waits, the pipeline is stalled for one cycle and the
// buffer is written. WB then re-presents its held write in the next cycle.
//
// Parameters:
//   AWL        register address width
//   DWL        data width
//   STARVE_MAX consecutive WB-won cycles tolerated with a buffered result (1..15)
//   ZERO_RO    1: writes to register 0 are suppressed (handshake still completes)
//
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   WB_WE/WB_WA/WB_WD          writeback write request (held while STALL=1)
//   MDU_VALID/MDU_WA/MDU_WD    MDU result offer
//   MDU_READY                  arbiter can accept an MDU result this cycle
//   RFWE/RFWA/RFWD             register file write port
//   STALL                      freezes the pipeline this cycle
//   GNT_MDU                    current RF write comes from the MDU buffer

module rf_write_arbiter #(
   parameter int AWL        = 5,
   parameter int DWL        = 32,
   parameter int STARVE_MAX = 3,
   parameter bit ZERO_RO    = 1'b1
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           WB_WE,
   input  logic [AWL-1:0] WB_WA,
   input  logic [DWL-1:0] WB_WD,
   input  logic           MDU_VALID,
   input  logic [AWL-1:0] MDU_WA,
   input  logic [DWL-1:0] MDU_WD,
   output logic           MDU_READY,
   output logic           RFWE,
   output logic [AWL-1:0] RFWA,
   output logic [DWL-1:0] RFWD,
   output logic           STALL,
   output logic           GNT_MDU
);

   typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

   localparam logic [3:0] SCNT_LIM = 4'(STARVE_MAX);

   state_t         state;
   logic           buf_v;
   logic [AWL-1:0] buf_a;
   logic [DWL-1:0] buf_d;
   logic [3:0]     scnt;

   logic           accept;
   logic           grant_buf;
   logic           sel_we;
   logic [AWL-1:0] sel_a;
   logic [DWL-1:0] sel_d;

   // Register 0 is hard-wired: drop the enable but let everything else
   // behave as if the write happened.
   function automatic logic mask_we(input logic we, input logic [AWL-1:0] wa);
      return we && !(ZERO_RO && (wa == '0));
   endfunction

   assign MDU_READY = !buf_v && !RST;
   assign accept    = MDU_VALID && MDU_READY;

   // STALL comes straight from the registered state so it cannot glitch.
   assign STALL     = (state == FORCE);

   // The buffer owns the port when WB is idle, or unconditionally in FORCE.
   assign grant_buf = (state == FORCE) || ((state == WAIT) && !WB_WE);

   always_comb begin
      sel_we = WB_WE;
      sel_a  = WB_WA;
      sel_d  = WB_WD;
      if (grant_buf) begin
         sel_we = 1'b1;
         sel_a  = buf_a;
         sel_d  = buf_d;
      end
   end

   // State is already IDLE during reset; the RST gating keeps the port quiet
   // even before the first clock after reset assertion.
   assign RFWE    = !RST && mask_we(sel_we, sel_a);
   assign RFWA    = RST ? '0 : sel_a;
   assign RFWD    = RST ? '0 : sel_d;
   assign GNT_MDU = grant_buf && !RST;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         buf_v <= 1'b0;
         scnt  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= WAIT;
                  buf_v <= 1'b1;
                  scnt  <= 4'd0;
               end
            end
            WAIT: begin
               if (!WB_WE) begin
                  state <= IDLE;
                  buf_v <= 1'b0;
                  scnt  <= 4'd0;
               end else begin
                  scnt <= scnt + 4'd1;
                  if (scnt + 4'd1 == SCNT_LIM) state <= FORCE;
               end
            end
            FORCE: begin
               state <= IDLE;
               buf_v <= 1'b0;
               scnt  <= 4'd0;
            end
            default: begin
               state <= IDLE;
               buf_v <= 1'b0;
               scnt  <= 4'd0;
            end
         endcase
      end
   end

   // Payload only; its validity is tracked by buf_v.
   always_ff @(posedge CLK) begin
      if (accept) begin
         buf_a <= MDU_WA;
         buf_d <= MDU_WD;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios followed by a
// randomized run checked against a behavioural model of the arbitration
// rules (pending MDU result + count of WB wins since it was buffered).

module tb_rf_write_arbiter;

   localparam int AWL  = 5;
   localparam int DWL  = 32;
   localparam int SMAX = 3;

   logic           CLK = 1'b0;
   logic           RST;
   logic           WB_WE;
   logic [AWL-1:0] WB_WA;
   logic [DWL-1:0] WB_WD;
   logic           MDU_VALID;
   logic [AWL-1:0] MDU_WA;
   logic [DWL-1:0] MDU_WD;
   logic           MDU_READY;
   logic           RFWE;
   logic [AWL-1:0] RFWA;
   logic [DWL-1:0] RFWD;
   logic           STALL;
   logic           GNT_MDU;

   int checks = 0;
   int errors = 0;

   // {RFWE, RFWA, RFWD, GNT_MDU, STALL, MDU_READY}
   logic [AWL+DWL+3:0] obs, exp_v;

   rf_write_arbiter #(.AWL(AWL), .DWL(DWL), .STARVE_MAX(SMAX), .ZERO_RO(1'b1)) dut (
      .CLK(CLK), .RST(RST),
      .WB_WE(WB_WE), .WB_WA(WB_WA), .WB_WD(WB_WD),
      .MDU_VALID(MDU_VALID), .MDU_WA(MDU_WA), .MDU_WD(MDU_WD),
      .MDU_READY(MDU_READY),
      .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
      .STALL(STALL), .GNT_MDU(GNT_MDU)
   );

   always #5 CLK = ~CLK;

   assign obs = {RFWE, RFWA, RFWD, GNT_MDU, STALL, MDU_READY};

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // 3 units after it, well clear of both edges.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_wb(input logic we, input logic [AWL-1:0] wa, input logic [DWL-1:0] wd);
      WB_WE = we; WB_WA = wa; WB_WD = wd;
   endtask

   task automatic set_mdu(input logic v, input logic [AWL-1:0] wa, input logic [DWL-1:0] wd);
      MDU_VALID = v; MDU_WA = wa; MDU_WD = wd;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      set_wb(1'b1, 5'd9, 32'h1111_2222);
      set_mdu(1'b1, 5'd4, 32'h3333_4444);
      tick(); tick();
      settle();
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, exp_v);
      end
      set_wb(1'b0, '0, '0);
      set_mdu(1'b0, '0, '0);
      tick();
      RST = 1'b0;
      settle();
      exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL after_reset got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_wb_pass();
      tick();
      set_wb(1'b1, 5'd5, 32'hDEADBEEF);
      settle();
      exp_v = {1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL wb_pass got=%h exp=%h", obs, exp_v);
      end
      tick();
      set_wb(1'b0, '0, '0);
   endtask

   task automatic test_mdu_idle();
      set_mdu(1'b1, 5'd7, 32'h0000_1234);
      settle();
      exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mdu_accept_cycle got=%h exp=%h", obs, exp_v);
      end
      tick();
      set_mdu(1'b0, '0, '0);
      settle();
      exp_v = {1'b1, 5'd7, 32'h0000_1234, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mdu_drain got=%h exp=%h", obs, exp_v);
      end
      tick();
      settle();
      exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mdu_ready_again got=%h exp=%h", obs, exp_v);
      end
      tick();
   endtask

   task automatic test_starve();
      logic [AWL-1:0] wa;
      logic [DWL-1:0] wd;
      // Accept while WB also writes.
      set_wb(1'b1, 5'd3, 32'hA0);
      set_mdu(1'b1, 5'd9, 32'hCAFE);
      settle();
      exp_v = {1'b1, 5'd3, 32'hA0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL starve_accept got=%h exp=%h", obs, exp_v);
      end
      tick();
      set_mdu(1'b0, '0, '0);
      // WB wins SMAX consecutive cycles.
      for (int i = 1; i <= SMAX; i++) begin
         wa = AWL'(10 + i);
         wd = 32'hB000 + 32'(i);
         set_wb(1'b1, wa, wd);
         settle();
         exp_v = {1'b1, wa, wd, 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL starve_wb_win%0d got=%h exp=%h", i, obs, exp_v);
         end
         tick();
      end
      // Stall cycle: WB write is held, buffer is written.
      set_wb(1'b1, 5'd20, 32'hC0DE);
      settle();
      exp_v = {1'b1, 5'd9, 32'hCAFE, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL starve_force got=%h exp=%h", obs, exp_v);
      end
      tick();
      // Held write re-presented and committed.
      settle();
      exp_v = {1'b1, 5'd20, 32'hC0DE, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL starve_replay got=%h exp=%h", obs, exp_v);
      end
      tick();
      set_wb(1'b1, 5'd21, 32'hC0DF);
      settle();
      exp_v = {1'b1, 5'd21, 32'hC0DF, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL starve_after got=%h exp=%h", obs, exp_v);
      end
      tick();
      set_wb(1'b0, '0, '0);
   endtask

   task automatic test_back_to_back();
      set_mdu(1'b1, 5'd10, 32'd111);
      tick();
      // Second result offered while the buffer is full and WB busy.
      set_mdu(1'b1, 5'd11, 32'd222);
      set_wb(1'b1, 5'd12, 32'd333);
      settle();
      exp_v = {1'b1, 5'd12, 32'd333, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_full got=%h exp=%h", obs, exp_v);
      end
      tick();
      set_wb(1'b0, '0, '0);
      settle();
      exp_v = {1'b1, 5'd10, 32'd111, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_drain_first got=%h exp=%h", obs, exp_v);
      end
      tick();
      settle();
      exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_accept_second got=%h exp=%h", obs, exp_v);
      end
      tick();
      set_mdu(1'b0, '0, '0);
      settle();
      exp_v = {1'b1, 5'd11, 32'd222, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_drain_second got=%h exp=%h", obs, exp_v);
      end
      tick();
   endtask

   task automatic test_zero_ro();
      set_mdu(1'b1, 5'd0, 32'd55);
      tick();
      set_mdu(1'b0, '0, '0);
      settle();
      exp_v = {1'b0, 5'd0, 32'd55, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL zero_mdu_drain got=%h exp=%h", obs, exp_v);
      end
      tick();
      settle();
      exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL zero_ready_back got=%h exp=%h", obs, exp_v);
      end
      set_wb(1'b1, 5'd0, 32'd77);
      settle();
      exp_v = {1'b0, 5'd0, 32'd77, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL zero_wb got=%h exp=%h", obs, exp_v);
      end
      tick();
      set_wb(1'b0, '0, '0);
   endtask

   task automatic test_reset_mid();
      int bad;
      set_wb(1'b1, 5'd14, 32'd1);
      set_mdu(1'b1, 5'd13, 32'd999);
      tick();
      set_mdu(1'b0, '0, '0);
      set_wb(1'b1, 5'd15, 32'd2);
      settle();
      exp_v = {1'b1, 5'd15, 32'd2, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL rstmid_wait got=%h exp=%h", obs, exp_v);
      end
      #1;
      RST = 1'b1;
      #1;
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL rstmid_immediate got=%h exp=%h", obs, exp_v);
      end
      tick();
      RST = 1'b0;
      set_wb(1'b0, '0, '0);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         settle();
         if (obs !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rstmid_no_stale bad_cycles=%0d exp=0", bad);
      end
   endtask

   task automatic test_random();
      // Model state: one pending MDU result and how many cycles WB has won
      // since it was buffered.
      bit             pend = 0;
      logic [AWL-1:0] pa = '0;
      logic [DWL-1:0] pd = '0;
      int             wins = 0;
      int             lat = 0;
      int             fails = 0;
      bit             stall_e, grant_e, ready_e, acc;
      logic           we_e;
      logic [AWL-1:0] a_e;
      logic [DWL-1:0] d_e;
      set_mdu(1'b0, '0, '0);
      set_wb(1'b0, '0, '0);
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!MDU_VALID && ($urandom_range(0, 2) == 0))
            set_mdu(1'b1, AWL'($urandom_range(0, 31)), $urandom);
         settle();
         stall_e = pend && (wins == SMAX);
         grant_e = pend && (stall_e || !WB_WE);
         ready_e = !pend;
         we_e = grant_e ? 1'b1 : WB_WE;
         a_e  = grant_e ? pa : WB_WA;
         d_e  = grant_e ? pd : WB_WD;
         if (a_e == '0) we_e = 1'b0;
         exp_v = {we_e, a_e, d_e, grant_e, stall_e, ready_e};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            fails++;
            if (fails <= 10)
               $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         // Worst-case latency from acceptance to write is SMAX+1 cycles.
         if (pend) lat++;
         checks++;
         if (lat > SMAX + 1) begin
            errors++;
            $display("FAIL random_latency cyc=%0d lat=%0d max=%0d", cyc, lat, SMAX + 1);
         end
         acc = MDU_VALID && ready_e;
         if (grant_e) begin
            pend = 0; wins = 0; lat = 0;
         end else if (pend && WB_WE) begin
            wins++;
         end
         if (acc) begin
            pend = 1; pa = MDU_WA; pd = MDU_WD; wins = 0; lat = 0;
         end
         tick();
         if (acc) set_mdu(1'b0, '0, '0);
         // After a stall cycle the pipeline re-presents the same WB write.
         if (!stall_e)
            set_wb(($urandom_range(0, 9) < 7), AWL'($urandom_range(0, 31)), $urandom);
      end
      set_wb(1'b0, '0, '0);
      set_mdu(1'b0, '0, '0);
   endtask

   initial begin
      RST = 1'b1;
      set_wb(1'b0, '0, '0);
      set_mdu(1'b0, '0, '0);
      test_reset();
      test_wb_pass();
      test_mdu_idle();
      test_starve();
      test_back_to_back();
      test_zero_ro();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (RFWE/RFWA/RFWD) between two requesters:
  - the pipeline writeback stage (WB), which cannot be back-pressured per write;
  - the multi-cycle multiply/divide unit (MDU), which uses a valid/ready handshake.
- Buffers one MDU result, fills idle WB cycles with it, and forces a one-cycle pipeline stall when the MDU has been starved too long.
- Sits between the WB stage, the MDU and the register file.

Parameters:
- AWL, 5, register address width.
- DWL, 32, data width.
- STARVE_MAX, 3, number of consecutive WB-won cycles tolerated while an MDU result is buffered (legal values 1..15).
- ZERO_RO, 1, when 1, writes to address 0 are suppressed (RFWE held low) while the handshake still completes.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- WB_WE  in  1  writeback write request; held stable by the pipeline while STALL=1.
- WB_WA  in  AWL  writeback address.
- WB_WD  in  DWL  writeback data.
- MDU_VALID  in  1  MDU result valid.
- MDU_WA  in  AWL  MDU destination address.
- MDU_WD  in  DWL  MDU result data.
- MDU_READY  out  1  arbiter can accept an MDU result this cycle.
- RFWE  out  1  register file write enable.
- RFWA  out  AWL  register file write address.
- RFWD  out  DWL  register file write data.
- STALL  out  1  freezes the pipeline (IF through WB) this cycle.
- GNT_MDU  out  1  the current RF write comes from the MDU buffer.

Behaviour:
- State registers:
  - buffer BUF_V / BUF_A / BUF_D;
  - starvation counter SCNT, width 4;
  - FSM with states IDLE, WAIT, FORCE.
- MDU handshake:
  - MDU_READY = !BUF_V and not in reset.
  - When MDU_VALID and MDU_READY are both high at an edge, the buffer captures MDU_WA/MDU_WD and BUF_V sets.
  - A result accepted at edge N is written to the RF no earlier than edge N+1.
- IDLE (BUF_V=0):
  - WB passes straight through: RFWE=WB_WE, RFWA=WB_WA, RFWD=WB_WD, GNT_MDU=0, STALL=0.
  - An accept moves the FSM to WAIT with SCNT=0.
- WAIT (BUF_V=1, STALL=0):
  - WB_WE=0: the buffer is granted (RFWE=1, RFWA=BUF_A, RFWD=BUF_D, GNT_MDU=1). BUF_V clears at the edge, SCNT goes to 0, next state IDLE.
  - WB_WE=1: WB is granted and SCNT increments. If SCNT+1 == STARVE_MAX, next state is FORCE.
- FORCE (BUF_V=1):
  - STALL=1 (decoded from the registered state, glitch-free).
  - The buffer is granted regardless of WB_WE.
  - At the edge BUF_V clears, SCNT goes to 0, next state IDLE.
  - The pipeline re-presents the held WB write in the following cycle.
- Back-to-back MDU results: no acceptance is possible while BUF_V=1, so a new result is accepted at the earliest in the cycle after the buffer drains.
- The WB path is combinational, zero latency; a WB write presented in cycle N commits at edge N.
- ZERO_RO=1 and the granted address is 0:
  - RFWE is forced to 0;
  - buffer drain, SCNT and FSM behave exactly as if the write had occurred.
- Ordering: the arbiter never reorders writes from the same source. WAW/RAW ordering between WB and MDU to the same register is decode's responsibility.
- Reset (asynchronous, at any point):
  - BUF_V=0, SCNT=0, FSM=IDLE.
  - While RST=1: RFWE=0, MDU_READY=0, STALL=0, GNT_MDU=0. RFWA/RFWD are don't-care but driven to 0.
  - A buffered MDU result is discarded; the MDU is reset by the same RST.
- SCNT cannot exceed STARVE_MAX.
- Worst-case MDU write latency from acceptance is STARVE_MAX+1 cycles.

Test Plan:
- Reset, then WB_WE=1, WB_WA=5, WB_WD=0xDEADBEEF -> same cycle RFWE=1, RFWA=5, RFWD=0xDEADBEEF, GNT_MDU=0, STALL=0, MDU_READY=1.
- MDU_VALID pulse with WA=7, WD=0x1234 while WB idle -> accepted; next cycle RFWE=1, RFWA=7, RFWD=0x1234, GNT_MDU=1; the cycle after, MDU_READY=1 again.
- MDU result buffered, WB_WE=1 for 6 straight cycles (STARVE_MAX=3) -> WB wins 3 cycles; 4th cycle STALL=1, GNT_MDU=1 with the MDU data; 5th cycle STALL=0 and the held WB write commits.
- MDU_VALID held high with two results while the buffer is full -> MDU_READY=0 until the drain cycle; the second result is accepted the cycle after the drain and no data is lost.
- ZERO_RO=1, MDU result with WA=0 -> RFWE stays 0, buffer drains, MDU_READY returns to 1; a WB write to address 0 also gives RFWE=0.
- RST asserted mid-cycle while BUF_V=1 in WAIT -> outputs go inactive immediately; after release, IDLE with no stale MDU write ever reaching the RF.
